// File: rtl/uart_hex_parser_if.sv
// uart_hex_parser_if: byte strobe in, parsed value and character outputs, echo handshake.
// master = UART side (drives rx_* and echo_ack); slave = the parser.
interface uart_hex_parser_if #(
  parameter int unsigned MAX_DIGITS = 4
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [4*MAX_DIGITS-1:0] value;
  logic                    value_valid;
  logic                    err;
  logic [3:0]              digit_count;
  logic [7:0]              last_char;
  logic [7:0]              prev_char;
  logic [7:0]              echo_data;
  logic                    echo_req;
  logic                    echo_ack;
  logic                    echo_ovf;

  modport master (
    output rx_data, rx_valid, echo_ack,
    input  value, value_valid, err, digit_count, last_char, prev_char,
    input  echo_data, echo_req, echo_ovf
  );

  modport slave (
    input  rx_data, rx_valid, echo_ack,
    output value, value_valid, err, digit_count, last_char, prev_char,
    output echo_data, echo_req, echo_ovf
  );
endinterface

// File: rtl/uart_hex_parser.sv
// uart_hex_parser: parses ASCII hex digits terminated by CR/LF into a binary value,
// flags malformed input, keeps the last two raw characters and optionally echoes bytes.
// Optional echo path is compiled in when HEX_PARSER_ECHO_EN is defined; otherwise the
// echo outputs are tied low and echo_ack is ignored.
module uart_hex_parser #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input logic              clk,
  input logic              rst,
  uart_hex_parser_if.slave bus
);
  localparam int unsigned VW = 4 * MAX_DIGITS;
  localparam logic [3:0] MaxCount = 4'(MAX_DIGITS);

  typedef enum logic [1:0] {StIdle, StDigits, StDiscard} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] accum_q, accum_d;
  logic [VW-1:0] value_q, value_d;
  logic [3:0]    count_q, count_d;
  logic          value_valid_q, value_valid_d;
  logic          err_q, err_d;
  logic [7:0]    last_q, prev_q;

  logic          is_hex, is_term, is_esc, is_space;
  logic [3:0]    nibble;
  logic [VW+3:0] shifted;

  // Byte classification and nibble decode (letters: low nibble + 9, case-insensitive).
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = bus.rx_data[3:0] + 4'd9;
    end
    is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    is_esc   = (bus.rx_data == 8'h1B);
    is_space = (bus.rx_data == 8'h20);
    shifted  = {accum_q, nibble};
  end

  // Parser next-state: accumulate digits, commit on terminator, discard after an error.
  always_comb begin
    state_d       = state_q;
    accum_d       = accum_q;
    count_d       = count_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    err_d         = 1'b0;
    if (bus.rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (is_hex) begin
            accum_d = VW'(nibble);
            count_d = 4'd1;
            state_d = StDigits;
          end else if (!is_term && !is_space && !is_esc) begin
            err_d   = 1'b1;
            state_d = StDiscard;
          end
        end
        StDigits: begin
          if (is_hex) begin
            if (count_q < MaxCount) begin
              accum_d = shifted[VW-1:0];
              count_d = count_q + 4'd1;
            end else begin
              err_d   = 1'b1;
              count_d = 4'd0;
              state_d = StDiscard;
            end
          end else if (is_term) begin
            value_d       = accum_q;
            value_valid_d = 1'b1;
            count_d       = 4'd0;
            state_d       = StIdle;
          end else if (is_esc) begin
            accum_d = '0;
            count_d = 4'd0;
            state_d = StIdle;
          end else if (!is_space) begin
            err_d   = 1'b1;
            count_d = 4'd0;
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          if (is_term || is_esc) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Parser state, committed value and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      accum_q       <= '0;
      count_q       <= 4'd0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      accum_q       <= accum_d;
      count_q       <= count_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      err_q         <= err_d;
    end
  end

  // Raw character history, updated on every byte regardless of parse state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 8'h00;
      prev_q <= 8'h00;
    end else if (bus.rx_valid) begin
      prev_q <= last_q;
      last_q <= bus.rx_data;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.err         = err_q;
  assign bus.digit_count = count_q;
  assign bus.last_char   = last_q;
  assign bus.prev_char   = prev_q;

`ifdef HEX_PARSER_ECHO_EN
  logic       echo_req_q, echo_ovf_q;
  logic [7:0] echo_data_q;
  logic       xfer;

  assign xfer = echo_req_q & bus.echo_ack;

  // Single-entry echo buffer: a byte arriving while one is still pending is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_req_q  <= 1'b0;
      echo_data_q <= 8'h00;
      echo_ovf_q  <= 1'b0;
    end else begin
      echo_ovf_q <= 1'b0;
      if (bus.rx_valid) begin
        if (!echo_req_q || xfer) begin
          echo_data_q <= bus.rx_data;
          echo_req_q  <= 1'b1;
        end else begin
          echo_ovf_q <= 1'b1;
        end
      end else if (xfer) begin
        echo_req_q <= 1'b0;
      end
    end
  end

  assign bus.echo_req  = echo_req_q;
  assign bus.echo_data = echo_data_q;
  assign bus.echo_ovf  = echo_ovf_q;
`else
  logic unused_echo_ack;
  assign unused_echo_ack = bus.echo_ack;
  assign bus.echo_req    = 1'b0;
  assign bus.echo_data   = 8'h00;
  assign bus.echo_ovf    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_hex_parser.sv
// tb_uart_hex_parser: directed scenarios plus randomized byte streams checked against a
// digit-list reference model of the hex parser and echo buffer.
module tb_uart_hex_parser;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned VW = 4 * MAX_DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  uart_hex_parser_if #(.MAX_DIGITS(MAX_DIGITS)) bus ();

  uart_hex_parser #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state.
  int            m_ndig;
  bit            m_bad;
  longint        m_acc;
  logic [VW-1:0] exp_value;
  logic          exp_vv, exp_err, exp_ovf, exp_req;
  logic [7:0]    exp_last, exp_prev, exp_edata;

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
    return -1;
  endfunction

  function void model_reset();
    m_ndig = 0; m_bad = 0; m_acc = 0;
    exp_value = '0; exp_vv = 0; exp_err = 0; exp_ovf = 0; exp_req = 0;
    exp_last = 0; exp_prev = 0; exp_edata = 0;
  endfunction

  // One clock edge worth of model behaviour.
  function void model_apply(input logic [7:0] b, input logic v, input logic ack);
    int n;
    exp_vv = 0; exp_err = 0; exp_ovf = 0;
`ifdef HEX_PARSER_ECHO_EN
    if (v) begin
      if (!exp_req || ack) begin exp_edata = b; exp_req = 1; end
      else exp_ovf = 1;
    end else if (exp_req && ack) begin
      exp_req = 0;
    end
`endif
    if (!v) return;
    exp_prev = exp_last;
    exp_last = b;
    n = hex_val(b);
    if (n >= 0) begin
      if (!m_bad) begin
        if (m_ndig == int'(MAX_DIGITS)) begin
          exp_err = 1; m_bad = 1; m_ndig = 0;
        end else begin
          m_acc  = (m_ndig == 0) ? longint'(n) : m_acc * 16 + n;
          m_ndig = m_ndig + 1;
        end
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (m_bad) m_bad = 0;
      else if (m_ndig > 0) begin exp_value = VW'(m_acc); exp_vv = 1; end
      m_ndig = 0;
    end else if (b == 8'h1B) begin
      m_bad = 0; m_ndig = 0; m_acc = 0;
    end else if (b != 8'h20) begin
      if (!m_bad) begin exp_err = 1; m_bad = 1; m_ndig = 0; end
    end
  endfunction

  task automatic step(input logic [7:0] b, input logic v, input logic ack);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = v;
    bus.echo_ack = ack;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.echo_ack = 1'b0;
    model_apply(b, v, ack);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({bus.value, bus.value_valid, bus.err, bus.digit_count, bus.last_char, bus.prev_char,
         bus.echo_data, bus.echo_req, bus.echo_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_state: got value=%h vv=%b err=%b cnt=%0d last=%h prev=%h req=%b, want all 0",
               bus.value, bus.value_valid, bus.err, bus.digit_count, bus.last_char,
               bus.prev_char, bus.echo_req);
    end
  endtask

  task automatic test_commit();
    step("1", 1, 0); step("a", 1, 0); step("F", 1, 0); step("3", 1, 0);
    total++;
    if (bus.digit_count !== 4'd4) begin
      bad++; $display("FAIL count_4: got %0d want 4", bus.digit_count);
    end
    step(8'h0D, 1, 0);
    total++;
    if (bus.value !== 16'h1AF3 || bus.value_valid !== 1'b1) begin
      bad++; $display("FAIL commit_1af3: got value=%h vv=%b want 1af3 1", bus.value, bus.value_valid);
    end
    step(8'h00, 0, 0);
    total++;
    if (bus.value_valid !== 1'b0 || bus.digit_count !== 4'd0 || bus.value !== 16'h1AF3) begin
      bad++; $display("FAIL commit_after: got vv=%b cnt=%0d value=%h want 0 0 1af3",
                      bus.value_valid, bus.digit_count, bus.value);
    end
    step("7", 1, 0); step(8'h0A, 1, 0);
    total++;
    if (bus.value !== 16'h0007 || bus.value_valid !== 1'b1) begin
      bad++; $display("FAIL commit_lf: got value=%h vv=%b want 0007 1", bus.value, bus.value_valid);
    end
    step(8'h0D, 1, 0);
    total++;
    if (bus.value !== 16'h0007 || bus.value_valid !== 1'b0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL bare_cr: got value=%h vv=%b err=%b want 0007 0 0",
                      bus.value, bus.value_valid, bus.err);
    end
  endtask

  task automatic test_overflow();
    step("1", 1, 0); step("2", 1, 0); step("3", 1, 0); step("4", 1, 0);
    step("5", 1, 0);
    total++;
    if (bus.err !== 1'b1 || bus.digit_count !== 4'd0) begin
      bad++; $display("FAIL overflow_err: got err=%b cnt=%0d want 1 0", bus.err, bus.digit_count);
    end
    step("9", 1, 0);
    total++;
    if (bus.err !== 1'b0 || bus.digit_count !== 4'd0) begin
      bad++; $display("FAIL discard_quiet: got err=%b cnt=%0d want 0 0", bus.err, bus.digit_count);
    end
    step(8'h0D, 1, 0);
    total++;
    if (bus.value_valid !== 1'b0 || bus.value !== 16'h0007) begin
      bad++; $display("FAIL discard_term: got vv=%b value=%h want 0 0007", bus.value_valid, bus.value);
    end
    step("9", 1, 0); step(8'h0D, 1, 0);
    total++;
    if (bus.value !== 16'h0009 || bus.value_valid !== 1'b1) begin
      bad++; $display("FAIL recover_9: got value=%h vv=%b want 0009 1", bus.value, bus.value_valid);
    end
  endtask

  task automatic test_bad_char();
    step("4", 1, 0); step("G", 1, 0);
    total++;
    if (bus.err !== 1'b1 || bus.last_char !== 8'h47 || bus.prev_char !== 8'h34) begin
      bad++; $display("FAIL bad_g: got err=%b last=%h prev=%h want 1 47 34",
                      bus.err, bus.last_char, bus.prev_char);
    end
    step(8'h00, 0, 0);
    total++;
    if (bus.err !== 1'b0) begin
      bad++; $display("FAIL err_single: got err=%b want 0", bus.err);
    end
    step(8'h0D, 1, 0); step("4", 1, 0); step(8'h1B, 1, 0);
    total++;
    if (bus.err !== 1'b0 || bus.digit_count !== 4'd0) begin
      bad++; $display("FAIL esc_clear: got err=%b cnt=%0d want 0 0", bus.err, bus.digit_count);
    end
    step(8'h0D, 1, 0);
    total++;
    if (bus.err !== 1'b0 || bus.value_valid !== 1'b0 || bus.value !== 16'h0009) begin
      bad++; $display("FAIL esc_cr: got err=%b vv=%b value=%h want 0 0 0009",
                      bus.err, bus.value_valid, bus.value);
    end
  endtask

`ifdef HEX_PARSER_ECHO_EN
  task automatic test_echo();
    do_reset();
    step(8'h41, 1, 0);
    total++;
    if (bus.echo_req !== 1'b1 || bus.echo_data !== 8'h41 || bus.echo_ovf !== 1'b0) begin
      bad++; $display("FAIL echo_load: got req=%b data=%h ovf=%b want 1 41 0",
                      bus.echo_req, bus.echo_data, bus.echo_ovf);
    end
    step(8'h42, 1, 0);
    total++;
    if (bus.echo_req !== 1'b1 || bus.echo_data !== 8'h41 || bus.echo_ovf !== 1'b1) begin
      bad++; $display("FAIL echo_ovf: got req=%b data=%h ovf=%b want 1 41 1",
                      bus.echo_req, bus.echo_data, bus.echo_ovf);
    end
    step(8'h00, 0, 1);
    total++;
    if (bus.echo_req !== 1'b0 || bus.echo_ovf !== 1'b0) begin
      bad++; $display("FAIL echo_ack: got req=%b ovf=%b want 0 0", bus.echo_req, bus.echo_ovf);
    end
    step(8'h00, 0, 1);
    total++;
    if (bus.echo_req !== 1'b0) begin
      bad++; $display("FAIL echo_idle_ack: got req=%b want 0", bus.echo_req);
    end
  endtask
`else
  task automatic test_echo();
    step(8'h41, 1, 1); step(8'h42, 1, 0); step(8'h00, 0, 1);
    total++;
    if (bus.echo_req !== 1'b0 || bus.echo_data !== 8'h00 || bus.echo_ovf !== 1'b0) begin
      bad++; $display("FAIL echo_tied: got req=%b data=%h ovf=%b want 0 00 0",
                      bus.echo_req, bus.echo_data, bus.echo_ovf);
    end
    step(8'h0D, 1, 0);
  endtask
`endif

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0, 1, 2: return 8'h30 + 8'($urandom_range(0, 9));
      3:       return 8'h41 + 8'($urandom_range(0, 5));
      4:       return 8'h61 + 8'($urandom_range(0, 5));
      5:       return ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      6:       return 8'h20;
      7:       return 8'h1B;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Mostly back-to-back strobes with occasional idle cycles and random acks.
  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic       ack;
      v   = ($urandom_range(0, 5) != 0);
      ack = ($urandom_range(0, 2) == 0);
      step(rand_byte(), v, ack);
      total++;
      if (bus.value !== exp_value) begin
        bad++; $display("FAIL rnd_value[%0d]: got %h want %h", i, bus.value, exp_value);
      end
      total++;
      if ({bus.value_valid, bus.err, bus.echo_ovf} !== {exp_vv, exp_err, exp_ovf}) begin
        bad++; $display("FAIL rnd_pulses[%0d]: got vv/err/ovf=%b%b%b want %b%b%b", i,
                        bus.value_valid, bus.err, bus.echo_ovf, exp_vv, exp_err, exp_ovf);
      end
      total++;
      if (bus.digit_count !== 4'(m_ndig)) begin
        bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.digit_count, m_ndig);
      end
      total++;
      if (bus.last_char !== exp_last || bus.prev_char !== exp_prev) begin
        bad++; $display("FAIL rnd_chars[%0d]: got %h/%h want %h/%h", i,
                        bus.last_char, bus.prev_char, exp_last, exp_prev);
      end
      total++;
      if (bus.echo_req !== exp_req || (exp_req && bus.echo_data !== exp_edata)) begin
        bad++; $display("FAIL rnd_echo[%0d]: got req=%b data=%h want %b %h", i,
                        bus.echo_req, bus.echo_data, exp_req, exp_edata);
      end
      total++;
      if (bus.value_valid === 1'b1 && bus.err === 1'b1) begin
        bad++; $display("FAIL rnd_exclusive[%0d]: got vv=1 err=1 want not both", i);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(8'h0D, 1, 0);
    step("A", 1, 0); step("B", 1, 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.value, bus.value_valid, bus.err, bus.digit_count, bus.last_char, bus.prev_char,
         bus.echo_data, bus.echo_req, bus.echo_ovf} !== '0) begin
      bad++;
      $display("FAIL async_reset: got value=%h cnt=%0d last=%h prev=%h req=%b, want all 0",
               bus.value, bus.digit_count, bus.last_char, bus.prev_char, bus.echo_req);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("C", 1, 0); step(8'h0D, 1, 0);
    total++;
    if (bus.value !== 16'h000C || bus.value_valid !== 1'b1) begin
      bad++; $display("FAIL after_reset_c: got value=%h vv=%b want 000c 1", bus.value, bus.value_valid);
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.echo_ack = 1'b0;
    model_reset();
    test_reset();
    test_commit();
    test_overflow();
    test_bad_char();
    test_echo();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
